// File: rtl/serial_twos_pkg.sv
// Shared types and constants for the bit-serial two's-complement subtractor.
package serial_twos_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int WIDTH_DEFAULT = 12;

  // Bit counter width for a given operand width.
  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

  localparam int CNT_W_DEFAULT = cnt_width(WIDTH_DEFAULT);

  // Saturation limits for a w-bit signed result (w <= 64).
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/serial_twos_sub_bit_cell.sv
// One-bit subtract cell: full adder on r and ~x plus the registered carry
// that is reused across the serial bit positions.
module sub_bit_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  input  logic r_bit,
  input  logic x_bit,
  output logic sum,
  output logic c_in_q,
  output logic c_out
);

  logic x_inv;
  logic c_q;
  logic c_d;

  assign x_inv  = ~x_bit;
  assign sum    = r_bit ^ x_inv ^ c_q;
  assign c_out  = (r_bit & x_inv) | (r_bit & c_q) | (x_inv & c_q);
  assign c_in_q = c_q;

  // Next carry: preset to 1 for the "+1" of negation, otherwise ripple forward.
  always_comb begin
    // NOTE: assign a default first so every path drives c_d and no latch is inferred.
    c_d = c_q;
    if (load) begin
      c_d = 1'b1;
    end else if (en) begin
      c_d = c_out;
    end
  end

  // Carry register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      c_q <= 1'b0;
    end else begin
      c_q <= c_d;
    end
  end

endmodule

// File: rtl/serial_twos_sub.sv
// Bit-serial r - x (computed as r + ~x + 1), LSB first, one bit per cycle,
// with borrow and signed-overflow flags behind a valid/ready handshake.
// Optional: define SERIAL_TWOS_SUB_SAT_EN to saturate diff on signed overflow.
module serial_twos_sub
  import serial_twos_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             t_clk,
  input  logic             nrst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] r,
  input  logic             neg_only,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int             CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
`ifdef SERIAL_TWOS_SUB_SAT_EN
  localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(sat_min(WIDTH));
`endif

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   x_q, x_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               borrow_q, borrow_d;
  logic               ovf_q, ovf_d;

  logic accept;
  logic shifting;
  logic sum;
  logic c_in_q;
  logic c_out;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_ready & in_valid;
  assign shifting  = (state_q == SHIFT);

  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign ovf    = ovf_q;

  sub_bit_cell u_cell (
    .clk    (t_clk),
    .rst_n  (nrst),
    .load   (accept),
    .en     (shifting),
    .r_bit  (r_q[cnt_q]),
    .x_bit  (x_q[cnt_q]),
    .sum    (sum),
    .c_in_q (c_in_q),
    .c_out  (c_out)
  );

  // Next-state, operand capture, serial shift and result/flag capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    r_d      = r_q;
    sh_d     = sh_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = x;
          r_d     = neg_only ? '0 : r;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        sh_d = {sum, sh_q[WIDTH-1:1]};
        if (cnt_q == LAST_BIT) begin
          state_d  = DONE;
          diff_d   = {sum, sh_q[WIDTH-1:1]};
          ovf_d    = c_in_q ^ c_out;
          borrow_d = ~c_out;
`ifdef SERIAL_TWOS_SUB_SAT_EN
          if (c_in_q ^ c_out) begin
            diff_d = (~r_q[WIDTH-1] & x_q[WIDTH-1]) ? SAT_POS : SAT_NEG;
          end
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Control and visible result registers, cleared by reset.
  always_ff @(posedge t_clk) begin
    if (!nrst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  // Operand and shift registers; always written before being read.
  always_ff @(posedge t_clk) begin
    // NOTE: no reset here: these are loaded on accept or shifted before any use.
    x_q  <= x_d;
    r_q  <= r_d;
    sh_q <= sh_d;
  end

endmodule

// File: tb/tb_serial_twos_sub.sv
// Self-checking bench for serial_twos_sub: arithmetic reference model,
// per-cycle result compare, and directed vectors with literal expectations.
// Build with SERIAL_TWOS_SUB_SAT_EN defined to check the saturating variant.
module tb_serial_twos_sub;

  localparam int W = 12;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
  } res_t;

  logic         t_clk = 1'b0;
  logic         nrst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] r;
  logic         neg_only;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf;

  int   checks   = 0;
  int   failures = 0;
  res_t exp_res  = '0;

  serial_twos_sub #(.WIDTH(W)) dut (
    .t_clk     (t_clk),
    .nrst      (nrst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .r         (r),
    .neg_only  (neg_only),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .ovf       (ovf)
  );

  always #5 t_clk = ~t_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic on the operands.
  function automatic res_t model(input logic [W-1:0] rv, input logic [W-1:0] xv, input logic neg);
    res_t         m;
    logic [W-1:0] ru;
    int           rs;
    int           xs;
    int           d;
    ru       = neg ? '0 : rv;
    rs       = $signed(ru);
    xs       = $signed(xv);
    d        = rs - xs;
    m.diff   = ru - xv;
    m.borrow = (ru < xv);
    m.ovf    = (d > 2047) || (d < -2048);
`ifdef SERIAL_TWOS_SUB_SAT_EN
    if (m.ovf) m.diff = (d > 0) ? 12'h7FF : 12'h800;
`endif
    return m;
  endfunction

  // Whenever a result is presented it must match the model for the accepted operands.
  always @(negedge t_clk) begin
    if (nrst === 1'b1 && out_valid === 1'b1) begin
      check("cmp_diff",   diff,   exp_res.diff);
      check("cmp_borrow", borrow, exp_res.borrow);
      check("cmp_ovf",    ovf,    exp_res.ovf);
    end
  end

  // Offer one operand pair; scramble inputs after accept; wait for the result.
  task automatic start_op(input logic [W-1:0] rv, input logic [W-1:0] xv, input logic neg);
    @(negedge t_clk);
    check("in_ready_before_accept", in_ready, 1'b1);
    r        = rv;
    x        = xv;
    neg_only = neg;
    in_valid = 1'b1;
    exp_res  = model(rv, xv, neg);
    @(posedge t_clk);
    #1;
    in_valid = 1'b0;
    r        = W'($urandom);
    x        = W'($urandom);
    neg_only = ~neg;
  endtask

  // Edges counted with the accept edge as 1; out_valid must appear after edge 13.
  task automatic wait_result(input string name);
    int k;
    k = 1;
    while (out_valid !== 1'b1 && k < 40) begin
      @(posedge t_clk);
      #1;
      k++;
    end
    check({name, "_latency"}, k, W + 1);
  endtask

  task automatic release_result();
    @(negedge t_clk);
    out_ready = 1'b1;
    @(posedge t_clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 1'b0);
    check("in_ready_after_done", in_ready, 1'b1);
  endtask

  task automatic run_op(input string name, input logic [W-1:0] rv, input logic [W-1:0] xv,
                        input logic neg, input logic [W-1:0] ed, input logic eb, input logic eo);
    start_op(rv, xv, neg);
    wait_result(name);
    check({name, "_diff"},   diff,   ed);
    check({name, "_borrow"}, borrow, eb);
    check({name, "_ovf"},    ovf,    eo);
    release_result();
  endtask

  logic [W-1:0] held;

  initial begin
    nrst      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = '0;
    r         = '0;
    neg_only  = 1'b0;
    repeat (3) @(posedge t_clk);
    #1;
    nrst = 1'b1;

    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_diff",      diff,      12'h000);
    check("rst_borrow",    borrow,    1'b0);
    check("rst_ovf",       ovf,       1'b0);

    run_op("t1_5m3",    12'h005, 12'h003, 1'b0, 12'h002, 1'b0, 1'b0);
    run_op("t2_3m5",    12'h003, 12'h005, 1'b0, 12'hFFE, 1'b1, 1'b0);
    run_op("t3_neg1",   12'h555, 12'h001, 1'b1, 12'hFFF, 1'b1, 1'b0);
`ifdef SERIAL_TWOS_SUB_SAT_EN
    run_op("t3_negmin", 12'h000, 12'h800, 1'b1, 12'h7FF, 1'b1, 1'b1);
    run_op("t4_ovf",    12'h7FF, 12'hFFF, 1'b0, 12'h7FF, 1'b1, 1'b1);
    run_op("t4b_novf",  12'h800, 12'h001, 1'b0, 12'h800, 1'b0, 1'b1);
`else
    run_op("t3_negmin", 12'h000, 12'h800, 1'b1, 12'h800, 1'b1, 1'b1);
    run_op("t4_ovf",    12'h7FF, 12'hFFF, 1'b0, 12'h800, 1'b1, 1'b1);
    run_op("t4b_novf",  12'h800, 12'h001, 1'b0, 12'h7FF, 1'b0, 1'b1);
`endif
    run_op("x_zero",    12'h123, 12'h000, 1'b0, 12'h123, 1'b0, 1'b0);

    // Backpressure: result holds, in_ready stays low and a new offer is ignored.
    start_op(12'h100, 12'h050, 1'b0);
    wait_result("t5");
    held = diff;
    check("t5_diff", held, 12'h0B0);
    for (int i = 0; i < 5; i++) begin
      @(negedge t_clk);
      in_valid = 1'b1;
      r        = 12'h7AA;
      x        = 12'h011;
      check("t5_hold_valid", out_valid, 1'b1);
      check("t5_hold_ready", in_ready,  1'b0);
      check("t5_hold_diff",  diff,      held);
    end
    @(negedge t_clk);
    in_valid = 1'b0;
    release_result();
    check("t5_diff_kept", diff, 12'h0B0);
    repeat (3) @(posedge t_clk);
    #1;
    check("t5_no_new_op", out_valid, 1'b0);

    // Reset while bit 6 is about to be processed aborts the operation.
    start_op(12'h3A5, 12'h111, 1'b0);
    repeat (6) @(posedge t_clk);
    #1;
    nrst = 1'b0;
    @(posedge t_clk);
    #1;
    nrst = 1'b1;
    check("t6_out_valid", out_valid, 1'b0);
    check("t6_diff",      diff,      12'h000);
    check("t6_in_ready",  in_ready,  1'b1);
    run_op("t6_fresh", 12'h010, 12'h001, 1'b0, 12'h00F, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_twos_sub.md
Name: serial_twos_sub

Overview:
- Downstream consumer of the 12-bit two's-complement negation stage.
- Bit-serially computes r - x as r + (~x) + 1, LSB first, one bit per t_clk cycle.
- Uses a single registered carry cell, matching the JK/flip-flop style of the negation stage.
- Produces a WIDTH-bit difference plus borrow and signed-overflow flags, behind a valid/ready handshake to the next stage.

Parameters:
- WIDTH, 12: operand and result width in bits; must be 2 or greater.

Ports:
- t_clk  input  1  sole clock; all state updates on the rising edge.
- nrst  input  1  reset; synchronous, active-low.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  block can accept an operand pair.
- x  input  WIDTH  subtrahend, two's complement.
- r  input  WIDTH  minuend, two's complement.
- neg_only  input  1  when 1, r is ignored and treated as 0, so the result is -x.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- diff  output  WIDTH  result of r - x, or -x when neg_only was 1.
- borrow  output  1  unsigned borrow: carry-out of the MSB stage, inverted.
- ovf  output  1  signed overflow: carry into the MSB differs from carry out of the MSB.

Behaviour:
- Reset (nrst=0 at an edge):
  - State goes to IDLE; bit counter = 0; carry register = 0.
  - diff = 0, borrow = 0, ovf = 0, out_valid = 0.
  - in_ready = 1 from the first cycle after reset.
  - Reset mid-operation aborts the operation; no partial result is ever presented.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid & in_ready: latch x, latch r (or 0 if neg_only), set carry = 1, set bit counter = 0, go to SHIFT.
- SHIFT:
  - in_ready = 0, out_valid = 0.
  - Each cycle handles bit i = counter:
    - s = r[i] ^ ~x[i] ^ c
    - c_next = majority(r[i], ~x[i], c)
  - s is shifted into the result register from the MSB side.
  - When i = WIDTH-1: record ovf = c ^ c_next and borrow = ~c_next, then go to DONE.
  - Takes exactly WIDTH cycles.
- DONE:
  - out_valid = 1; diff, borrow and ovf are stable.
  - Holds indefinitely while out_ready = 0.
  - On out_ready = 1: go to IDLE. Outputs keep their last values, and out_valid drops on the next cycle.
- Latency: out_valid rises WIDTH+1 cycles after the accept edge.
- Throughput: one operation per WIDTH+2 cycles. There is no overlap, because in_ready = 0 outside IDLE.
- Inputs are sampled only on the accept edge. Changes to x, r or neg_only afterwards have no effect on the operation in progress.
- out_ready is ignored in IDLE and SHIFT.
- in_valid is ignored in SHIFT and DONE.
- Boundary conditions:
  - x = 0: result equals r; borrow = 0 (carry out = 1).
  - neg_only with x = 0x800 gives diff = 0x800 and ovf = 1.
  - Counter wraps to 0 only via a new accept.

Optional Feature:
- Macro: SERIAL_TWOS_SUB_SAT_EN.
- Defined:
  - In DONE, when ovf = 1, diff is replaced by the saturated value.
  - Saturated value is 0x7FF (max positive) if r is non-negative and x is negative; otherwise 0x800 (min negative).
  - ovf still reports 1.
  - Latency unchanged; saturation is applied in the SHIFT to DONE transition cycle.
- Undefined: diff is the raw wrapped WIDTH-bit sum.

Decomposition:
- Package serial_twos_pkg holds:
  - state enum typedef (IDLE, SHIFT, DONE), 2 bits;
  - WIDTH_DEFAULT = 12;
  - counter width localparam, computed as $clog2(WIDTH);
  - saturation constants derived from WIDTH.
- Sub-module sub_bit_cell: one-bit full adder with the ~x inversion, plus the registered carry flip-flop.
  - Cell ports: clock, reset, load (preset carry to 1), enable, r_bit, x_bit, sum, c_in_q, c_out.
  - The top level instantiates it once and reuses it across cycles.

Test Plan:
1. r=0x005, x=0x003, neg_only=0 -> diff=0x002, borrow=0, ovf=0; out_valid exactly 13 cycles after accept.
2. r=0x003, x=0x005 -> diff=0xFFE, borrow=1, ovf=0.
3. neg_only=1 with x=0x001 -> diff=0xFFF. With x=0x800 -> diff=0x800 and ovf=1 (diff=0x7FF with SAT_EN).
4. r=0x7FF, x=0xFFF -> diff=0x800, ovf=1, borrow=1. With SAT_EN -> diff=0x7FF.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE -> diff and flags stable, in_ready=0, and a new in_valid is ignored. Then out_ready=1 -> IDLE, and in_ready=1 the next cycle.
6. nrst=0 at SHIFT bit 6 -> next cycle out_valid=0, diff=0, in_ready=1. A fresh r=0x010, x=0x001 then gives diff=0x00F.
